// File: rtl/writeback_stage.sv
// MIPS writeback stage: retires ALU results and loads onto the decoder_stage register-file write port.
// Optional WB_LOAD_EXT_EN: opcode-driven byte/half load extraction; otherwise loads commit the raw word.
module writeback_stage #(
  parameter int AWIDTH  = 5,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic              wb_i_ce,
  input  logic              wb_i_valid,
  output logic              wb_o_ready,
  input  logic [5:0]        wb_i_opcode,
  input  logic              wb_i_reg_wr,
  input  logic              wb_i_reg_dst,
  input  logic              wb_i_mem_to_reg,
  input  logic [AWIDTH-1:0] wb_i_rd_addr,
  input  logic [DWIDTH-1:0] wb_i_alu_result,
  input  logic              wb_i_mem_ack,
  input  logic [DWIDTH-1:0] wb_i_mem_data,
  output logic              wb_o_reg_wr,
  output logic              wb_o_reg_dst,
  output logic [AWIDTH-1:0] wb_o_rd_addr,
  output logic [DWIDTH-1:0] wb_o_data_rd,
  output logic              wb_o_stall,
  output logic              wb_o_err
);

  localparam int CW_RAW = $clog2(TIMEOUT + 1);
  localparam int CW     = (CW_RAW < 4) ? 4 : CW_RAW;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE,
    S_WAIT_MEM
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AWIDTH-1:0] ld_rd_q, ld_rd_d;
  logic              ld_dst_q, ld_dst_d;
  logic              ld_wr_q, ld_wr_d;

  logic              reg_wr_q, reg_wr_d;
  logic              reg_dst_q, reg_dst_d;
  logic [AWIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic              commit_en;
  logic              commit_wr;
  logic [AWIDTH-1:0] commit_addr;
  logic              commit_dst;
  logic [DWIDTH-1:0] commit_data;

  logic [DWIDTH-1:0] load_word;

`ifdef WB_LOAD_EXT_EN
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  logic [5:0]  ld_op_q, ld_op_d;
  logic [1:0]  ld_lane_q, ld_lane_d;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Little-endian lanes; halves take only addr[1], addr[0] is ignored.
  always_comb begin
    lane_byte = wb_i_mem_data[{ld_lane_q, 3'b000} +: 8];
    lane_half = ld_lane_q[1] ? wb_i_mem_data[31:16] : wb_i_mem_data[15:0];
    case (ld_op_q)
      OP_LB:   load_word = {{(DWIDTH-8){lane_byte[7]}}, lane_byte};
      OP_LBU:  load_word = {{(DWIDTH-8){1'b0}}, lane_byte};
      OP_LH:   load_word = {{(DWIDTH-16){lane_half[15]}}, lane_half};
      OP_LHU:  load_word = {{(DWIDTH-16){1'b0}}, lane_half};
      default: load_word = wb_i_mem_data;
    endcase
  end
`else
  logic unused_opcode;
  assign unused_opcode = ^wb_i_opcode;
  assign load_word     = wb_i_mem_data;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ld_rd_d     = ld_rd_q;
    ld_dst_d    = ld_dst_q;
    ld_wr_d     = ld_wr_q;
`ifdef WB_LOAD_EXT_EN
    ld_op_d     = ld_op_q;
    ld_lane_d   = ld_lane_q;
`endif
    err_d       = 1'b0;
    commit_en   = 1'b0;
    commit_wr   = 1'b0;
    commit_addr = '0;
    commit_dst  = 1'b0;
    commit_data = '0;

    case (state_q)
      S_IDLE: begin
        if (wb_i_ce && wb_i_valid) begin
          if (wb_i_mem_to_reg) begin
            ld_rd_d  = wb_i_rd_addr;
            ld_dst_d = wb_i_reg_dst;
            ld_wr_d  = wb_i_reg_wr;
`ifdef WB_LOAD_EXT_EN
            ld_op_d   = wb_i_opcode;
            ld_lane_d = wb_i_alu_result[1:0];
`endif
            cnt_d   = '0;
            state_d = S_WAIT_MEM;
          end else begin
            commit_en   = 1'b1;
            commit_wr   = wb_i_reg_wr;
            commit_addr = wb_i_rd_addr;
            commit_dst  = wb_i_reg_dst;
            commit_data = wb_i_alu_result;
          end
        end
      end
      S_WAIT_MEM: begin
        if (wb_i_mem_ack) begin
          commit_en   = 1'b1;
          commit_wr   = ld_wr_q;
          commit_addr = ld_rd_q;
          commit_dst  = ld_dst_q;
          commit_data = load_word;
          state_d     = S_IDLE;
        // Counter starts at 0, so the last allowed wait cycle sees TIMEOUT-1:
        // the stall lasts exactly TIMEOUT cycles.
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output registers only move on an effective write; $zero and no-write
  // instructions retire without disturbing the held write-port values.
  always_comb begin
    reg_wr_d  = 1'b0;
    reg_dst_d = reg_dst_q;
    rd_addr_d = rd_addr_q;
    data_d    = data_q;
    if (commit_en && commit_wr && (commit_addr != '0)) begin
      reg_wr_d  = 1'b1;
      reg_dst_d = commit_dst;
      rd_addr_d = commit_addr;
      data_d    = commit_data;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ld_rd_q   <= '0;
      ld_dst_q  <= 1'b0;
      ld_wr_q   <= 1'b0;
`ifdef WB_LOAD_EXT_EN
      ld_op_q   <= '0;
      ld_lane_q <= '0;
`endif
      reg_wr_q  <= 1'b0;
      reg_dst_q <= 1'b0;
      rd_addr_q <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_rd_q   <= ld_rd_d;
      ld_dst_q  <= ld_dst_d;
      ld_wr_q   <= ld_wr_d;
`ifdef WB_LOAD_EXT_EN
      ld_op_q   <= ld_op_d;
      ld_lane_q <= ld_lane_d;
`endif
      reg_wr_q  <= reg_wr_d;
      reg_dst_q <= reg_dst_d;
      rd_addr_q <= rd_addr_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  assign wb_o_ready   = (state_q == S_IDLE);
  assign wb_o_stall   = (state_q == S_WAIT_MEM);
  assign wb_o_reg_wr  = reg_wr_q;
  assign wb_o_reg_dst = reg_dst_q;
  assign wb_o_rd_addr = rd_addr_q;
  assign wb_o_data_rd = data_q;
  assign wb_o_err     = err_q;

endmodule
